// File: rtl/procesor_pkg.sv
// rtl/procesor_pkg.sv - shared types and constants for the RAM arbiter
// Purpose: lock-state encoding, requester index constants and the default
//          data width used by ram_arbiter and its round-robin picker.
// Ports:   none (package)
package procesor_pkg;

    // Data word width used by the processor datapath.
    localparam int DATA_W_DEFAULT = 16;

    // Requester indices: control unit load/store path and external I/O port.
    localparam logic REQ_CU = 1'b0;
    localparam logic REQ_IO = 1'b1;

    // Ownership of the RAM for atomic read-modify-write sequences.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } lock_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin / fixed-priority picker
// Purpose: chooses at most one of two requesters after applying the lock mask.
// Ports:
//   req[1:0]     raw request lines (bit n = requester n)
//   last_served  index of the requester granted most recently
//   mask[1:0]    eligibility mask from the lock owner (1 = may be granted)
//   grant[1:0]   one-hot (or zero) grant
module rr_pick2
    import procesor_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] eligible;

    assign eligible = req & mask;

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                // On a conflict the requester that was not served last wins,
                // unless requester 0 has absolute priority.
                if (FIXED_PRIO != 0) begin
                    grant = 2'b01;
                end else if (last_served == REQ_IO) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the single-port data RAM between CU and I/O
// Purpose: valid/ready-style arbitration of two requesters onto one RAM port,
//          with round-robin or fixed priority, an ownership lock for atomic
//          sequences and saturating per-requester grant counters.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   r0_* / r1_*               requester n: req, we, lock, addr, wdata in;
//                             gnt, rvalid, rdata out
//   ram_addr, ram_we, ram_in  RAM command (combinational from the winner)
//   ram_out                   RAM read data, one cycle after a read address
//   gnt_cnt0, gnt_cnt1        saturating grant counters
module ram_arbiter
    import procesor_pkg::*;
#(
    parameter int RAM_SIZE   = 8,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                r0_req,
    input  logic                r0_we,
    input  logic                r0_lock,
    input  logic [RAM_SIZE-1:0] r0_addr,
    input  logic [DATA_W-1:0]   r0_wdata,
    output logic                r0_gnt,
    output logic                r0_rvalid,
    output logic [DATA_W-1:0]   r0_rdata,

    input  logic                r1_req,
    input  logic                r1_we,
    input  logic                r1_lock,
    input  logic [RAM_SIZE-1:0] r1_addr,
    input  logic [DATA_W-1:0]   r1_wdata,
    output logic                r1_gnt,
    output logic                r1_rvalid,
    output logic [DATA_W-1:0]   r1_rdata,

    output logic [RAM_SIZE-1:0] ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_in,
    input  logic [DATA_W-1:0]   ram_out,

    output logic [CNT_W-1:0]    gnt_cnt0,
    output logic [CNT_W-1:0]    gnt_cnt1
);

    lock_state_e         state;
    lock_state_e         state_nxt;
    logic                last_served;
    logic [1:0]          mask;
    logic [1:0]          pick;
    logic [RAM_SIZE-1:0] hold_addr;
    logic [DATA_W-1:0]   hold_in;

    // Only the lock owner is eligible while a lock is held.
    always_comb begin
        mask = 2'b11;
        case (state)
            OWN0:    mask = 2'b01;
            OWN1:    mask = 2'b10;
            default: mask = 2'b11;
        endcase
    end

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req         ({r1_req, r0_req}),
        .last_served (last_served),
        .mask        (mask),
        .grant       (pick)
    );

    // Grants are suppressed combinationally while reset is held.
    assign r0_gnt = rst & pick[0];
    assign r1_gnt = rst & pick[1];

    // RAM command mux; address and write data hold their last value when idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = hold_addr;
        ram_in   = hold_in;
        if (r0_gnt) begin
            ram_we   = r0_we;
            ram_addr = r0_addr;
            ram_in   = r0_wdata;
        end else if (r1_gnt) begin
            ram_we   = r1_we;
            ram_addr = r1_addr;
            ram_in   = r1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr <= '0;
            hold_in   <= '0;
        end else begin
            hold_addr <= ram_addr;
            hold_in   <= ram_in;
        end
    end

    // Read return: one-cycle pulse aligned with ram_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= r0_gnt & ~r0_we;
            r1_rvalid <= r1_gnt & ~r1_we;
        end
    end

    assign r0_rdata = r0_rvalid ? ram_out : '0;
    assign r1_rdata = r1_rvalid ? ram_out : '0;

    // Reset value REQ_IO makes requester 0 win the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_served <= REQ_IO;
        end else if (r0_gnt) begin
            last_served <= REQ_CU;
        end else if (r1_gnt) begin
            last_served <= REQ_IO;
        end
    end

    // Lock is taken only together with a grant and released on the first
    // clock the owner's lock line is low; the release takes effect next cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: begin
                if (r0_gnt && r0_lock) begin
                    state_nxt = OWN0;
                end else if (r1_gnt && r1_lock) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!r0_lock) begin
                    state_nxt = UNLOCKED;
                end
            end
            OWN1: begin
                if (!r1_lock) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating debug counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (r0_gnt && (gnt_cnt0 != '1)) begin
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            end
            if (r1_gnt && (gnt_cnt1 != '1)) begin
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port data RAM between two requesters: requester 0 is the control unit's load/store path, and requester 1 is the external I/O port (data_in/data_out transfers).
- Valid/ready-style handshake per requester.
- Round-robin or fixed-priority arbitration.
- Optional lock for atomic read-modify-write sequences.
- Per-requester grant counters for debug.
Sits between CONTROL_UNIT/IO logic and RAM inside procesor.

Parameters:
RAM_SIZE, 8, RAM address width in bits
DATA_W, 16, data word width
FIXED_PRIO, 0, 1 = requester 0 always wins; 0 = round-robin
CNT_W, 16, width of saturating grant counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write enable (1 = write, 0 = read)
r0_lock  in  1  requester 0 holds exclusive ownership while high
r0_addr  in  RAM_SIZE  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  requester 0 access accepted this cycle
r0_rvalid  out  1  requester 0 read data valid
r0_rdata  out  DATA_W  requester 0 read data
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
ram_addr  out  RAM_SIZE  RAM address
ram_we  out  1  RAM write enable
ram_in  out  DATA_W  RAM write data
ram_out  in  DATA_W  RAM read data, valid one cycle after address with we=0
gnt_cnt0  out  CNT_W  grants issued to requester 0
gnt_cnt1  out  CNT_W  grants issued to requester 1

Behaviour:
- Handshake: an access completes in the cycle where rN_req=1 and rN_gnt=1. The requester holds addr/we/wdata stable while req=1 and gnt=0. If req stays high after a gnt, the next cycle is a new access.
- rN_gnt is combinational from req, lock owner and the priority pointer. At most one gnt is high per cycle. gnt is never high without its req.
- RAM side is a combinational mux of the granted requester's addr/we/wdata. With no grant: ram_we=0, ram_addr/ram_in hold the last-driven values.
- Read return: registered rN_rvalid=1 in the cycle after a granted read (we=0), for exactly one cycle. rN_rdata=ram_out, masked to 0 when rN_rvalid=0. Writes never produce rvalid.
- Throughput: one access per cycle, back-to-back reads allowed. Read latency is 1 cycle from gnt.
- Round-robin (FIXED_PRIO=0): register last_served updates on every grant. On simultaneous requests, the requester that is not last_served wins. A lone requester is granted immediately. Starvation bound: 1 intervening access.
- FIXED_PRIO=1: requester 0 wins every conflict; last_served is still tracked but ignored.
- Lock state machine, states UNLOCKED, OWN0, OWN1:
  - UNLOCKED to OWNn when requester n is granted with rN_lock=1.
  - In OWNn, only requester n can be granted; the other waits regardless of priority.
  - OWNn to UNLOCKED at the first clock where rN_lock=0, whether or not a req is present. This is a registered transition: the other requester can win in the cycle after lock drops.
  - A lock asserted without a grant has no effect.
- Counters: gnt_cntN increments on each rN_gnt and saturates at all-ones, no wrap.
- Reset (rst low, asynchronous):
  - state=UNLOCKED, last_served=1 (requester 0 wins the first conflict).
  - rvalid=0, counters=0, ram_addr=0, ram_in=0.
  - gnt and ram_we are forced 0 while rst is low.
  - A read granted in the cycle of reset assertion produces no rvalid.

Decomposition:
- Shared package procesor_pkg holds the lock-state enum (UNLOCKED/OWN0/OWN1), requester index constants REQ_CU=0 and REQ_IO=1, and the DATA_W default.
- One natural sub-module, rr_pick2: the 2-way round-robin/fixed-priority pick, inputs req[1:0], last_served, mask[1:0], FIXED_PRIO; output one-hot grant.

Test Plan:
- Reset mid-read:
  - Stimulus: r0 reads addr 0x10; rst pulled low in the grant cycle.
  - Required: no r0_rvalid follows; all outputs 0; gnt_cnt0=0 after reset.
- Conflict, round-robin:
  - Stimulus: r0 and r1 both read continuously.
  - Required: grants alternate r0,r1,r0,... starting with r0. Each rvalid arrives 1 cycle later on the matching requester. gnt_cnt0=gnt_cnt1=4 after 8 cycles.
- Write then read:
  - Stimulus: r1 writes 0xBEEF to 0x05, then reads 0x05.
  - Required: ram_we=1 for exactly one cycle; r1_rvalid=1 with r1_rdata=0xBEEF.
- Lock:
  - Stimulus: r0 asserts lock and does read 0x20, then write 0x20, while r1_req is held high.
  - Required: r1_gnt stays 0 until the cycle after r0_lock falls, then r1 is granted.
- Fixed priority:
  - Stimulus: FIXED_PRIO=1, both requesters request for 5 cycles.
  - Required: r0 granted all 5 cycles; r1_gnt=0 throughout.
- Counter saturation:
  - Stimulus: CNT_W=4, r0 granted 20 times.
  - Required: gnt_cnt0=15 and holds at 15.
